// File: rtl/axi4_lite_master_bridge.sv
// Single-command request port to AXI4-Lite master bridge; one transaction in flight at a time.
// Optional stall timeout is compiled in when AXI4_LITE_MASTER_TIMEOUT_EN is defined.
module axi4_lite_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      aw_valid,
    input  logic                      aw_ready,
    output logic [ADDR_WIDTH-1:0]     aw_addr,
    output logic                      w_valid,
    input  logic                      w_ready,
    output logic [DATA_WIDTH-1:0]     w_data,
    output logic [DATA_WIDTH/8-1:0]   w_strb,
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [1:0]                b_resp,
    output logic                      ar_valid,
    input  logic                      ar_ready,
    output logic [ADDR_WIDTH-1:0]     ar_addr,
    input  logic                      r_valid,
    output logic                      r_ready,
    input  logic [DATA_WIDTH-1:0]     r_data,
    input  logic [1:0]                r_resp
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || ADDR_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("axi4_lite_master_bridge: illegal parameter combination");
    end

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        WR_REQ  = 5'b00010,
        WR_RESP = 5'b00100,
        RD_REQ  = 5'b01000,
        RD_DATA = 5'b10000
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    aw_valid_q, aw_valid_d;
    logic                    w_valid_q, w_valid_d;
    logic                    ar_valid_q, ar_valid_d;
    logic                    b_ready_q, b_ready_d;
    logic                    r_ready_q, r_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    // Only the SLVERR/DECERR bit of each response matters to the requester.
    logic unused_resp_lsb;
    assign unused_resp_lsb = b_resp[0] ^ r_resp[0];

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_hit;

    // The counter reaches TIMEOUT_CYCLES on the edge that ends this cycle.
    assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        ar_valid_d  = ar_valid_q;
        b_ready_d   = b_ready_q;
        r_ready_d   = r_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = WR_REQ;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // Each channel's valid doubles as its not-yet-done flag.
                if (aw_ready) aw_valid_d = 1'b0;
                if (w_ready)  w_valid_d  = 1'b0;
                if (!aw_valid_d && !w_valid_d) begin
                    b_ready_d = 1'b1;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_valid) begin
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = b_resp[1];
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end
            end
            RD_REQ: begin
                if (ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_valid) begin
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = r_resp[1];
                    rsp_rdata_d = r_data;
                    state_d     = IDLE;
                end
            end
            default: begin
                aw_valid_d = 1'b0;
                w_valid_d  = 1'b0;
                ar_valid_d = 1'b0;
                b_ready_d  = 1'b0;
                r_ready_d  = 1'b0;
                state_d    = IDLE;
            end
        endcase

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
        // A handshake completing in the limit cycle wins over the timeout.
        if (state_q != IDLE && state_d == state_q && to_hit) begin
            aw_valid_d  = 1'b0;
            w_valid_d   = 1'b0;
            ar_valid_d  = 1'b0;
            b_ready_d   = 1'b0;
            r_ready_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = IDLE;
        end
`endif
    end

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    always_comb begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (state_q == IDLE || state_d != state_q) to_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            b_ready_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            ar_valid_q  <= ar_valid_d;
            b_ready_q   <= b_ready_d;
            r_ready_q   <= r_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Holding cmd_ready low during the response cycle keeps the next accept one cycle later.
    assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign aw_valid  = aw_valid_q;
    assign aw_addr   = addr_q;
    assign w_valid   = w_valid_q;
    assign w_data    = wdata_q;
    assign w_strb    = wstrb_q;
    assign b_ready   = b_ready_q;
    assign ar_valid  = ar_valid_q;
    assign ar_addr   = addr_q;
    assign r_ready   = r_ready_q;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Bench for axi4_lite_master_bridge: directed vector table, reset-abort sequence and random
// traffic against a memory/latency reference model; timeout case when the macro is defined.
module tb_axi4_lite_master_bridge;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic [AW-1:0] aw_addr, ar_addr;
    logic [DW-1:0] w_data, r_data;
    logic [SW-1:0] w_strb;
    logic [1:0]    b_resp, r_resp;
    logic          ar_valid, ar_ready, r_valid, r_ready;

    axi4_lite_master_bridge #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        int            aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]    resp;
        bit            force_en;
        logic [DW-1:0] force_d;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
        int            exp_lat;
    } vec_t;

    typedef struct {
        int            lat, aw_n, w_n, ar_n, b_n, r_n;
        logic [DW-1:0] rdata;
        logic          err;
    } obs_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] smem [1024];   // what the slave actually received over AXI
    logic [DW-1:0] rmem [1024];   // what the command stream says memory should hold

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        for (int i = 0; i < SW; i++) if (s[i]) rmem[a][8*i +: 8] = d[8*i +: 8];
    endfunction

    function automatic int exp_latency(input vec_t v);
        if (v.wr) return ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + 3 + v.b_d;
        return v.ar_d + 3 + v.r_d;
    endfunction

    function automatic vec_t mk(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [SW-1:0] s, input int awd, input int wd, input int bd,
                                input int ard, input int rd, input logic [1:0] resp, input bit fe,
                                input logic [DW-1:0] fd, input logic [DW-1:0] er, input bit ee, input int el);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.strb = s;
        v.aw_d = awd; v.w_d = wd; v.b_d = bd; v.ar_d = ard; v.r_d = rd;
        v.resp = resp; v.force_en = fe; v.force_d = fd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    task automatic slave_idle();
        aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
        b_valid = 1'b0; b_resp = 2'b00; r_valid = 1'b0; r_resp = 2'b00; r_data = '0;
    endtask

    // Issues one command and plays the slave with the requested per-channel delays.
    task automatic do_txn(input vec_t v, output obs_t o);
        int cyc, b_age, r_age;
        bit done, awd, wd, ard, bt, rt, aw_pend, w_pend, ar_pend;
        logic [AW-1:0] ca, cra;
        logic [DW-1:0] cd;
        logic [SW-1:0] cs;
        o = '{default: 0};
        b_age = 0; r_age = 0; done = 0; awd = 0; wd = 0; ard = 0; bt = 0; rt = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0; ca = '0; cra = '0; cd = '0; cs = '0;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.strb;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_write = ~v.wr; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_wstrb = ~v.strb;
        cyc = 1;
        while (!done && cyc <= 300) begin
            if (awd && wd) b_age++;
            if (ard) r_age++;
            if (rsp_valid) begin
                done = 1; o.lat = cyc; o.rdata = rsp_rdata; o.err = rsp_err;
                chk("cmd_ready_in_rsp", 32'(cmd_ready), 32'd0);
            end else begin
                if (aw_pend) chk("aw_valid_hold", 32'(aw_valid), 32'd1);
                if (w_pend)  chk("w_valid_hold", 32'(w_valid), 32'd1);
                if (ar_pend) chk("ar_valid_hold", 32'(ar_valid), 32'd1);
            end
            if (aw_valid) begin o.aw_n++; chk("aw_addr", 32'(aw_addr), 32'(v.addr)); end
            if (w_valid) begin
                o.w_n++;
                chk("w_data", w_data, v.wdata);
                chk("w_strb", 32'(w_strb), 32'(v.strb));
            end
            if (ar_valid) begin o.ar_n++; chk("ar_addr", 32'(ar_addr), 32'(v.addr)); end
            aw_ready = aw_valid && (o.aw_n > v.aw_d);
            w_ready  = w_valid && (o.w_n > v.w_d);
            ar_ready = ar_valid && (o.ar_n > v.ar_d);
            b_valid  = awd && wd && !bt && (b_age > v.b_d);
            b_resp   = b_valid ? v.resp : 2'b00;
            r_valid  = ard && !rt && (r_age > v.r_d);
            r_resp   = r_valid ? v.resp : 2'b00;
            r_data   = r_valid ? (v.force_en ? v.force_d : smem[cra]) : '0;
            aw_pend  = aw_valid && !aw_ready;
            w_pend   = w_valid && !w_ready;
            ar_pend  = ar_valid && !ar_ready;
            if (aw_valid && aw_ready) begin awd = 1; ca = aw_addr; end
            if (w_valid && w_ready) begin wd = 1; cd = w_data; cs = w_strb; end
            if (ar_valid && ar_ready) begin ard = 1; cra = ar_addr; end
            if (b_valid && b_ready) begin
                bt = 1; o.b_n++;
                for (int i = 0; i < SW; i++) if (cs[i]) smem[ca][8*i +: 8] = cd[8*i +: 8];
            end
            if (r_valid && r_ready) begin rt = 1; o.r_n++; end
            @(posedge clk); #1;
            cyc++;
        end
        slave_idle();
        if (!done) begin
            chk("rsp_wait_expired", 32'd0, 32'd1);
        end else begin
            chk("rsp_single_pulse", 32'(rsp_valid), 32'd0);
            chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_aw_valid"}, 32'(aw_valid), 32'd0);
        chk({tag, "_w_valid"}, 32'(w_valid), 32'd0);
        chk({tag, "_ar_valid"}, 32'(ar_valid), 32'd0);
        chk({tag, "_b_ready"}, 32'(b_ready), 32'd0);
        chk({tag, "_r_ready"}, 32'(r_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_aw_addr"}, 32'(aw_addr), 32'd0);
        chk({tag, "_ar_addr"}, 32'(ar_addr), 32'd0);
        chk({tag, "_w_data"}, w_data, 32'd0);
        chk({tag, "_w_strb"}, 32'(w_strb), 32'd0);
    endtask

    task automatic check_obs(input string tag, input vec_t v, input obs_t o);
        chk({tag, "_rdata"}, o.rdata, v.exp_rdata);
        chk({tag, "_err"}, 32'(o.err), 32'(v.exp_err));
        chk({tag, "_latency"}, 32'(o.lat), 32'(v.exp_lat));
        if (v.wr) begin
            chk({tag, "_aw_cycles"}, 32'(o.aw_n), 32'(v.aw_d + 1));
            chk({tag, "_w_cycles"}, 32'(o.w_n), 32'(v.w_d + 1));
            chk({tag, "_b_count"}, 32'(o.b_n), 32'd1);
        end else begin
            chk({tag, "_ar_cycles"}, 32'(o.ar_n), 32'(v.ar_d + 1));
            chk({tag, "_r_count"}, 32'(o.r_n), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vec_t v;
        obs_t o;

        for (int i = 0; i < 1024; i++) begin smem[i] = '0; rmem[i] = '0; end
        vecs[0] = mk(1, 10'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0, 0, 3);
        vecs[1] = mk(0, 10'h010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'hDEADBEEF, 0, 3);
        vecs[2] = mk(1, 10'h020, 32'h11223344, 4'hF, 3, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0, 0, 6);
        vecs[3] = mk(0, 10'h000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 1, 32'h12345678, 32'h12345678, 1, 3);
        vecs[4] = mk(1, 10'h010, 32'hAABBCCDD, 4'h5, 0, 2, 0, 0, 0, 2'b00, 0, 0, 32'h0, 0, 5);
        vecs[5] = mk(0, 10'h010, 32'h0, 4'h0, 0, 0, 0, 2, 1, 2'b00, 0, 0, 32'hDEBBBEDD, 0, 6);
        vecs[6] = mk(1, 10'h030, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 0, 2'b11, 0, 0, 32'h0, 1, 3);
        vecs[7] = mk(1, 10'h031, 32'h01020304, 4'hC, 0, 3, 2, 0, 0, 2'b00, 0, 0, 32'h0, 0, 8);
        vecs[8] = mk(0, 10'h020, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 32'h11223344, 0, 3);
        vecs[9] = mk(0, 10'h031, 32'h0, 4'h0, 0, 0, 0, 0, 4, 2'b00, 0, 0, 32'h01020000, 0, 7);

        rst_n = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        slave_idle();
        #2 rst_n = 1'b0;
        #1 check_reset_values("por");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            do_txn(vecs[i], o);
            check_obs($sformatf("vec%0d", i), vecs[i], o);
            if (vecs[i].wr) ref_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
        end

        // Reset while waiting for B: the write is abandoned and a late B is ignored.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h040; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("rst_seq_aw_valid", 32'(aw_valid), 32'd1);
        aw_ready = 1'b1; w_ready = 1'b1;
        @(posedge clk); #1;
        aw_ready = 1'b0; w_ready = 1'b0;
        chk("rst_seq_b_ready", 32'(b_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        b_valid = 1'b1; b_resp = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("midrst_no_b_ready", 32'(b_ready), 32'd0);
        end
        b_valid = 1'b0;
        v = mk(0, 10'h040, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0, 0, 3);
        do_txn(v, o);
        check_obs("after_rst", v, o);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
        v = mk(0, 10'h050, 32'h0, 4'h0, 0, 0, 0, 1000, 0, 2'b00, 0, 0, 32'h0, 1, TO + 1);
        do_txn(v, o);
        chk("to_latency", 32'(o.lat), 32'(TO + 1));
        chk("to_err", 32'(o.err), 32'd1);
        chk("to_rdata", o.rdata, 32'd0);
        chk("to_ar_cycles", 32'(o.ar_n), 32'(TO));
        chk("to_r_count", 32'(o.r_n), 32'd0);
`endif

        for (int i = 0; i < 60; i++) begin
            v.wr = bit'($urandom_range(0, 1));
            v.addr = 10'h100 + 10'($urandom_range(0, 15));
            v.wdata = $urandom;
            v.strb = 4'($urandom_range(0, 15));
            v.aw_d = $urandom_range(0, 3); v.w_d = $urandom_range(0, 3); v.b_d = $urandom_range(0, 3);
            v.ar_d = $urandom_range(0, 3); v.r_d = $urandom_range(0, 3);
            v.resp = 2'($urandom_range(0, 3));
            v.force_en = 0; v.force_d = '0;
            v.exp_rdata = v.wr ? 32'h0 : rmem[v.addr];
            v.exp_err = v.resp[1];
            v.exp_lat = exp_latency(v);
            do_txn(v, o);
            check_obs($sformatf("rnd%0d", i), v, o);
            if (v.wr) ref_write(v.addr, v.wdata, v.strb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master_bridge.md
Name: axi4_lite_master_bridge

Overview:
- Converts a simple single-command request port into AXI4-Lite master transactions.
- Sits directly upstream of the team's AXI4-Lite RAM slave and drives its AW/W/B/AR/R channels.
- Used by test sequencers and the simple core to access slave memory.
- One outstanding transaction at a time; no pipelining.

Parameters:
DATA_WIDTH, 32, data bus width in bits (multiple of 8)
ADDR_WIDTH, 10, address width in bits
TIMEOUT_CYCLES, 255, stall limit in cycles; used only when TIMEOUT_EN is defined

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  bridge can accept a command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  one-cycle pulse: transaction complete
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_err  out  1  1 = non-OKAY response or timeout
aw_valid  out  1  AXI write-address valid
aw_ready  in  1  AXI write-address ready
aw_addr  out  ADDR_WIDTH  AXI write address
w_valid  out  1  AXI write-data valid
w_ready  in  1  AXI write-data ready
w_data  out  DATA_WIDTH  AXI write data
w_strb  out  DATA_WIDTH/8  AXI write strobes
b_valid  in  1  AXI write-response valid
b_ready  out  1  AXI write-response ready
b_resp  in  2  AXI write response
ar_valid  out  1  AXI read-address valid
ar_ready  in  1  AXI read-address ready
ar_addr  out  ADDR_WIDTH  AXI read address
r_valid  in  1  AXI read-data valid
r_ready  out  1  AXI read-data ready
r_data  in  DATA_WIDTH  AXI read data
r_resp  in  2  AXI read response

Behaviour:
- Reset: state IDLE.
- Reset values: all *_valid, b_ready, r_ready, rsp_valid and rsp_err are 0; address, data and strobe registers are 0; cmd_ready is 1.
- Reset mid-transaction: abandons it immediately; no response is produced.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA. One-hot encoding.
- IDLE:
  - cmd_ready = 1 only in IDLE.
  - On cmd_valid, register addr/wdata/wstrb.
  - Go to WR_REQ if cmd_write, else RD_REQ.
  - aw_valid/w_valid (or ar_valid) are asserted from the next cycle, all outputs registered.
- WR_REQ:
  - aw_valid and w_valid are asserted together.
  - Each is dropped independently on the cycle after its ready is sampled high (per-channel done flags).
  - AW and W may complete in either order or in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - b_ready = 1.
  - On b_valid: rsp_valid pulse, rsp_err = b_resp[1], rsp_rdata = 0, return to IDLE.
- RD_REQ:
  - ar_valid = 1 until ar_ready is sampled high, then go to RD_DATA.
- RD_DATA:
  - r_ready = 1.
  - On r_valid: rsp_valid pulse, rsp_rdata = r_data, rsp_err = r_resp[1], return to IDLE.
- Valids are never deasserted before their handshake (AXI rule), except on timeout.
- Addresses and data are held stable while their valid is high.
- Minimum latency with a zero-wait slave:
  - Write: accept at cycle 0, AW/W at cycle 1, B at cycle 2, rsp_valid at cycle 3.
  - Read: identical cycle pattern.
- A new command is accepted no earlier than the cycle after rsp_valid.

Optional Feature:
- Macro: AXI4_LITE_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter, sized for TIMEOUT_CYCLES, clears on every state change and counts in each non-IDLE state.
  - Reaching TIMEOUT_CYCLES forces: all valids and readies to 0, rsp_valid pulse, rsp_err = 1, rsp_rdata = 0, return to IDLE.
  - Late slave responses after a timeout are ignored (readies are 0).
- Undefined: no counter logic; the bridge waits indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
- Write 0xDEADBEEF to addr 0x010, strobe 0xF, zero-wait slave -> AW/W at cycle 1, rsp_valid at cycle 3, rsp_err = 0, rsp_rdata = 0.
- Read addr 0x010 after the write above -> ar_addr = 0x010, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Write where aw_ready is delayed 3 cycles and w_ready is immediate -> w_valid drops after 1 cycle, aw_valid is held 4 cycles, exactly one B is accepted, one rsp_valid.
- Read with r_resp = 2'b10 and r_data = 0x12345678 -> rsp_err = 1, rsp_rdata = 0x12345678.
- Assert rst_n low during WR_RESP -> all outputs return to reset values asynchronously; no rsp_valid; next command proceeds normally.
- With TIMEOUT_EN defined, TIMEOUT_CYCLES = 16, slave never asserts ar_ready -> ar_valid drops after 16 cycles, rsp_valid with rsp_err = 1, cmd_ready = 1 on the next cycle.
